// File: rtl/instruction_prefetch_unit_if.sv
// Fetch-side bundle: ROM request/response, redirect input and the instruction stream to the core.
// master = prefetch unit, slave = ROM plus consumer side.
interface instruction_prefetch_unit_if #(
  parameter int unsigned XLEN        = 64,
  parameter int unsigned INSTR_WIDTH = 32
);
  logic                   mem_enable;
  logic [XLEN-1:0]        mem_address;
  logic [INSTR_WIDTH-1:0] mem_data;
  logic                   mem_busy;
  logic                   redirect;
  logic [XLEN-1:0]        redirect_address;
  logic [INSTR_WIDTH-1:0] instruction;
  logic [XLEN-1:0]        instruction_address;
  logic                   instruction_valid;
  logic                   instruction_ready;
  logic                   fifo_full;

  modport master (
    output mem_enable,
    output mem_address,
    input  mem_data,
    input  mem_busy,
    input  redirect,
    input  redirect_address,
    output instruction,
    output instruction_address,
    output instruction_valid,
    input  instruction_ready,
    output fifo_full
  );

  modport slave (
    input  mem_enable,
    input  mem_address,
    output mem_data,
    output mem_busy,
    output redirect,
    output redirect_address,
    input  instruction,
    input  instruction_address,
    input  instruction_valid,
    output instruction_ready,
    input  fifo_full
  );
endinterface

// File: rtl/instruction_prefetch_unit.sv
// Instruction prefetch front-end: issues one fetch at a time to a busy-handshaked ROM and
// buffers returned words with their PCs in a DEPTH-entry FIFO; redirect flushes everything.
module instruction_prefetch_unit #(
  parameter int unsigned     XLEN        = 64,
  parameter int unsigned     INSTR_WIDTH = 32,
  parameter int unsigned     DEPTH       = 4,
  parameter logic [XLEN-1:0] RESET_PC    = '0
) (
  input logic                         clock,
  input logic                         reset,
  instruction_prefetch_unit_if.master bus
);

  localparam int unsigned PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [PtrW:0] DepthCnt = (PtrW + 1)'(DEPTH);

  typedef enum logic [1:0] {StIdle, StRequest, StWait, StDiscard} state_e;

  state_e                 state_q, state_d;
  logic [XLEN-1:0]        pc_q, pc_d;
  logic [PtrW:0]          count_q, count_d;
  logic [PtrW-1:0]        head_q, tail_q;
  logic                   req_q;
  logic [INSTR_WIDTH-1:0] data_mem [DEPTH];
  logic [XLEN-1:0]        addr_mem [DEPTH];
  logic                   resp, push, pop;

  always_comb begin
    // The cycle right after the request the ROM has not raised busy yet, so ignore it.
    resp = ((state_q == StWait) || (state_q == StDiscard)) && !req_q && !bus.mem_busy;
    push = (state_q == StWait) && resp && !bus.redirect;
    pop  = (count_q != '0) && bus.instruction_ready && !bus.redirect;

    state_d = state_q;
    unique case (state_q)
      StIdle:    if (!bus.redirect && (count_q < DepthCnt)) state_d = StRequest;
      StRequest: state_d = bus.redirect ? StDiscard : StWait;
      StWait: begin
        if (bus.redirect) state_d = StDiscard;
        else if (resp)    state_d = StIdle;
      end
      StDiscard: if (resp && !bus.redirect) state_d = StIdle;
      default:   state_d = StIdle;
    endcase

    pc_d = pc_q;
    if (bus.redirect) pc_d = bus.redirect_address & ~XLEN'(3);
    else if (push)    pc_d = pc_q + XLEN'(4);

    count_d = count_q;
    if (bus.redirect)       count_d = '0;
    else if (push && !pop)  count_d = count_q + 1'b1;
    else if (pop && !push)  count_d = count_q - 1'b1;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= StIdle;
      pc_q    <= RESET_PC;
      count_q <= '0;
      head_q  <= '0;
      tail_q  <= '0;
      req_q   <= 1'b0;
      for (int i = 0; i < int'(DEPTH); i++) begin
        data_mem[i] <= '0;
        addr_mem[i] <= '0;
      end
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      count_q <= count_d;
      req_q   <= (state_q == StRequest);
      if (bus.redirect) begin
        head_q <= '0;
        tail_q <= '0;
      end else begin
        if (push) begin
          data_mem[tail_q] <= bus.mem_data;
          addr_mem[tail_q] <= pc_q;
          tail_q           <= tail_q + 1'b1;
        end
        if (pop) head_q <= head_q + 1'b1;
      end
    end
  end

  assign bus.mem_enable          = (state_q == StRequest);
  assign bus.mem_address         = pc_q;
  assign bus.instruction         = data_mem[head_q];
  assign bus.instruction_address = addr_mem[head_q];
  assign bus.instruction_valid   = (count_q != '0);
  assign bus.fifo_full           = (count_q == DepthCnt);

endmodule

// File: tb/tb_instruction_prefetch_unit.sv
// Bench for instruction_prefetch_unit: cycle-stepped ROM model plus a queue/PC reference model,
// directed scenarios followed by a randomized ready/redirect/latency phase.
module tb_instruction_prefetch_unit;
  localparam int unsigned XLEN  = 64;
  localparam int unsigned IW    = 32;
  localparam int unsigned DEPTH = 4;
  localparam logic [63:0] RESET_PC2 = 64'hFFFF_FFFF_FFFF_FFF8;

  logic clock = 1'b0;
  logic reset;
  always #5 clock = ~clock;

  instruction_prefetch_unit_if #(.XLEN(XLEN), .INSTR_WIDTH(IW)) bus ();
  instruction_prefetch_unit_if #(.XLEN(XLEN), .INSTR_WIDTH(IW)) bus2 ();

  instruction_prefetch_unit #(
    .XLEN(XLEN), .INSTR_WIDTH(IW), .DEPTH(DEPTH), .RESET_PC(64'h0)
  ) dut (
    .clock(clock), .reset(reset), .bus(bus)
  );

  instruction_prefetch_unit #(
    .XLEN(XLEN), .INSTR_WIDTH(IW), .DEPTH(DEPTH), .RESET_PC(RESET_PC2)
  ) dut2 (
    .clock(clock), .reset(reset), .bus(bus2)
  );

  typedef struct packed {
    logic [31:0] data;
    logic [63:0] addr;
  } entry_t;

  entry_t      q[$];
  logic [63:0] pc;
  bit          rom_active;
  int          rom_rem;
  logic [63:0] rom_addr;
  bit          discard;
  int          rom_lat;
  bit          lat_rand;
  int          errors;
  int          checks;
  int          idle_run;
  int          n2;
  int          pop2;
  bit          wrap_seen;
  int          me_count;
  bit          me_seen;
  logic [63:0] me_addr;

  function automatic logic [31:0] rom_word(logic [63:0] a);
    return (a[31:0] * 32'd2654435761) ^ a[63:32] ^ 32'h5A5A_0F0F;
  endfunction

  task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    logic        me, red, rdy, v, rst, me2, v2, ret_now;
    logic [63:0] ma, ra, ma2, ia2;
    logic [31:0] i2, wd;
    entry_t      e;
    me  = bus.mem_enable;
    ma  = bus.mem_address;
    red = bus.redirect;
    ra  = bus.redirect_address;
    rdy = bus.instruction_ready;
    v   = bus.instruction_valid;
    rst = reset;
    me2 = bus2.mem_enable;
    ma2 = bus2.mem_address;
    v2  = bus2.instruction_valid;
    ia2 = bus2.instruction_address;
    i2  = bus2.instruction;
    me_seen = me && !rst;
    me_addr = ma;
    if (!rst) begin
      if (me) begin
        me_count++;
        chk("enable_addr", ma, pc);
        chk("enable_while_busy", rom_active, 0);
        chk("enable_with_space", q.size() < DEPTH, 1);
      end
      if (me || red || rom_active || q.size() == DEPTH) idle_run = 0;
      else begin
        idle_run++;
        chk("request_prompt", idle_run <= 2, 1);
      end
      if (me2) begin
        chk("wrap_enable_addr", ma2, RESET_PC2 + 64'(4 * n2));
        if (ma2 == 64'h0) wrap_seen = 1;
        n2++;
      end
      if (v2) begin
        chk("wrap_head_addr", ia2, RESET_PC2 + 64'(4 * pop2));
        chk("wrap_head_data", i2, rom_word(RESET_PC2 + 64'(4 * pop2)));
        pop2++;
      end
    end else idle_run = 0;

    @(posedge clock);
    #1;

    ret_now = 0;
    wd = rom_word(rom_addr);
    if (rom_active) begin
      if (rom_rem == 0) begin
        ret_now = 1;
        rom_active = 0;
      end else rom_rem--;
    end
    if (me) begin
      rom_active = 1;
      rom_rem = lat_rand ? int'($urandom_range(1, 3)) : rom_lat;
      rom_addr = ma;
    end

    if (rst) begin
      q.delete();
      pc = 64'h0;
      discard = 1;
      n2 = 0;
      pop2 = 0;
    end else begin
      if (v && rdy && !red && q.size() > 0) void'(q.pop_front());
      if (ret_now && !discard && !red) begin
        e.data = wd;
        e.addr = pc;
        q.push_back(e);
        pc = pc + 64'd4;
      end
      if (me) discard = 0;
      if (red) begin
        q.delete();
        pc = ra & ~64'h3;
        discard = 1;
      end
    end

    bus.mem_busy = rom_active && (rom_rem > 0);
    bus.mem_data = (rom_active && rom_rem == 0) ? rom_word(rom_addr) : $urandom();
    if (me2) bus2.mem_data = rom_word(ma2);

    if (rst) begin
      chk("rst_enable", bus.mem_enable, 0);
      chk("rst_addr", bus.mem_address, 64'h0);
      chk("rst_valid", bus.instruction_valid, 0);
      chk("rst_full", bus.fifo_full, 0);
      chk("rst_addr2", bus2.mem_address, RESET_PC2);
    end else begin
      chk("valid", bus.instruction_valid, q.size() != 0);
      chk("full", bus.fifo_full, q.size() == DEPTH);
      if (q.size() != 0) begin
        chk("head_data", bus.instruction, q[0].data);
        chk("head_addr", bus.instruction_address, q[0].addr);
      end else begin
        chk("head_xfree", $isunknown({bus.instruction, bus.instruction_address}), 0);
      end
    end
  endtask

  task automatic do_reset(int n);
    reset = 1;
    repeat (n) step();
    reset = 0;
  endtask

  task automatic wait_me(string tag, int budget);
    bit ok = 0;
    for (int i = 0; i < budget && !ok; i++) begin
      step();
      ok = me_seen;
    end
    chk(tag, ok, 1);
  endtask

  initial begin
    int cyc;
    bit ok;
    errors = 0; checks = 0; idle_run = 0; n2 = 0; pop2 = 0; wrap_seen = 0; me_count = 0;
    rom_active = 0; rom_rem = 0; rom_addr = 0; discard = 1; rom_lat = 1; lat_rand = 0;
    pc = 0;
    reset = 1;
    bus.redirect = 0; bus.redirect_address = 0; bus.instruction_ready = 0;
    bus.mem_busy = 0; bus.mem_data = 0;
    bus2.redirect = 0; bus2.redirect_address = 0; bus2.instruction_ready = 1;
    bus2.mem_busy = 0; bus2.mem_data = 0;

    // Sequential fetch, ROM busy two cycles, always ready.
    rom_lat = 2;
    bus.instruction_ready = 1;
    do_reset(3);
    cyc = 0;
    ok = 0;
    for (int i = 1; i <= 20 && !ok; i++) begin
      step();
      cyc = i;
      ok = bus.instruction_valid;
    end
    chk("first_valid_seen", ok, 1);
    chk("first_valid_latency", cyc >= 4, 1);
    chk("first_valid_addr", bus.instruction_address, 64'h0);
    repeat (25) step();

    // Consumer stalled: fill to DEPTH, no further requests, one pop reopens fetch at 16.
    bus.instruction_ready = 0;
    rom_lat = 1;
    do_reset(2);
    ok = 0;
    for (int i = 0; i < 60 && !ok; i++) begin
      step();
      ok = bus.fifo_full;
    end
    chk("fill_full", ok, 1);
    me_count = 0;
    repeat (10) step();
    chk("no_enable_when_full", me_count, 0);
    bus.instruction_ready = 1;
    step();
    bus.instruction_ready = 0;
    wait_me("refetch_timeout", 10);
    chk("refetch_addr", me_addr, 64'd16);
    repeat (6) step();

    // Redirect while waiting on the ROM.
    do_reset(2);
    rom_lat = 3;
    wait_me("s3_req_timeout", 10);
    step();
    bus.redirect = 1;
    bus.redirect_address = 64'h103;
    step();
    bus.redirect = 0;
    chk("redir_valid", bus.instruction_valid, 0);
    wait_me("s3_redir_timeout", 20);
    chk("redir_addr", me_addr, 64'h100);
    repeat (10) step();

    // Redirect and pop together with three entries buffered.
    do_reset(2);
    rom_lat = 1;
    ok = 0;
    for (int i = 0; i < 60 && !ok; i++) begin
      step();
      ok = (q.size() == 3);
    end
    chk("s4_three_entries", ok, 1);
    bus.redirect = 1;
    bus.instruction_ready = 1;
    bus.redirect_address = {$urandom(), $urandom()};
    step();
    bus.redirect = 0;
    bus.instruction_ready = 0;
    chk("flush_valid", bus.instruction_valid, 0);
    chk("flush_full", bus.fifo_full, 0);
    repeat (8) step();

    // Randomized traffic, including redirects near the top of the address space.
    lat_rand = 1;
    for (int i = 0; i < 500; i++) begin
      bus.instruction_ready = ($urandom_range(0, 9) < 7);
      bus.redirect = ($urandom_range(0, 19) == 0);
      bus.redirect_address = {$urandom(), $urandom()};
      if ($urandom_range(0, 3) == 0)
        bus.redirect_address = 64'hFFFF_FFFF_FFFF_FFE0 | 64'($urandom_range(0, 31));
      step();
    end
    bus.redirect = 0;
    lat_rand = 0;

    // Reset in the middle of a slow fetch; the late response must be ignored.
    rom_lat = 5;
    bus.instruction_ready = 0;
    wait_me("s6_req_timeout", 20);
    step();
    step();
    reset = 1;
    repeat (8) step();
    reset = 0;
    chk("reset_mid_addr", bus.mem_address, 64'h0);
    chk("reset_mid_valid", bus.instruction_valid, 0);
    repeat (12) step();

    chk("wrap_seen", wrap_seen, 1);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
